// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: one conditional add/subtract plus arithmetic shift per RUN cycle.
// Optional unsigned operation (mode_signed port) is enabled by defining MULT_UNSIGNED_MODE_EN.
module booth_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  output logic               ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef MULT_UNSIGNED_MODE_EN
  input  logic               mode_signed,
`endif
  output logic [2*WIDTH-1:0] product,
  output logic               mult_DONE,
  output logic               busy
);

  // Storage is sized for the widest mode; signed mode runs fewer iterations over it.
`ifdef MULT_UNSIGNED_MODE_EN
  localparam int unsigned WM = WIDTH + 1;
`else
  localparam int unsigned WM = WIDTH;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WM:0]        a_q, a_d;
  logic [WM-1:0]      q_q, q_d;
  logic [WM-1:0]      m_q, m_d;
  logic               qprev_q, qprev_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [5:0]         cnt_last;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WM-1:0]      m_in, q_in;
  logic [WM:0]        m_ext, a_sum;

`ifdef MULT_UNSIGNED_MODE_EN
  logic sgn_q, sgn_d;

  assign m_in     = {mode_signed & multiplicand[WIDTH-1], multiplicand};
  assign q_in     = {mode_signed & multiplier[WIDTH-1], multiplier};
  assign cnt_last = sgn_q ? 6'(WIDTH - 1) : 6'(WIDTH);
  assign sgn_d    = (state_q == StIdle && valid) ? mode_signed : sgn_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sgn_q <= 1'b1;
    end else begin
      sgn_q <= sgn_d;
    end
  end
`else
  assign m_in     = multiplicand;
  assign q_in     = multiplier;
  assign cnt_last = 6'(WIDTH - 1);
`endif

  assign m_ext = {m_q[WM-1], m_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    qprev_d   = qprev_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    a_sum     = a_q;

    unique case (state_q)
      StIdle: begin
        if (valid) begin
          m_d     = m_in;
          q_d     = q_in;
          a_d     = '0;
          qprev_d = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        unique case ({q_q[0], qprev_q})
          2'b01:   a_sum = a_q + m_ext;
          2'b10:   a_sum = a_q - m_ext;
          default: a_sum = a_q;
        endcase
        a_d     = {a_sum[WM], a_sum[WM:1]};
        q_d     = {a_sum[0], q_q[WM-1:1]};
        qprev_d = q_q[0];
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == cnt_last) begin
          state_d = StDone;
`ifdef MULT_UNSIGNED_MODE_EN
          // Signed mode leaves the unconsumed extension bit in q_d[0].
          if (sgn_q) begin
            product_d = {a_d[WIDTH-1:0], q_d[WM-1:1]};
          end else begin
            product_d = {a_d[WIDTH-2:0], q_d};
          end
`else
          product_d = {a_d[WIDTH-1:0], q_d};
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qprev_q   <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qprev_q   <= qprev_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign ready     = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign mult_DONE = (state_q == StDone);
  assign product   = product_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: random and corner operands against an integer product model.
// Unsigned-mode scenarios run only when MULT_UNSIGNED_MODE_EN is defined.
module tb_booth_multiplier;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic               valid;
  logic               ready;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] product;
  logic               mult_DONE;
  logic               busy;
`ifdef MULT_UNSIGNED_MODE_EN
  logic               mode_signed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  booth_multiplier #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .ready        (ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef MULT_UNSIGNED_MODE_EN
    .mode_signed  (mode_signed),
`endif
    .product      (product),
    .mult_DONE    (mult_DONE),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input bit sgn);
    int pa, pb;
    if (sgn) begin
      pa = int'($signed(a));
      pb = int'($signed(b));
    end else begin
      pa = int'(a);
      pb = int'(b);
    end
    return (2*WIDTH)'(pa * pb);
  endfunction

  // One transaction; returns observations, comparisons are made by the callers.
  // lat counts negedges after the accept edge up to and including the mult_DONE cycle.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit sgn,
                       output logic [2*WIDTH-1:0] prod, output int lat, output bit got,
                       output bit rdy_err, output logic after_done, output logic after_ready);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
`ifdef MULT_UNSIGNED_MODE_EN
    mode_signed  = sgn;
`else
    if (!sgn) $display("note: unsigned request ignored in signed-only build");
`endif
    valid = 1'b1;
    @(posedge clk);
    got     = 1'b0;
    lat     = 0;
    rdy_err = 1'b0;
    prod    = '0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        valid        = 1'b0;
        multiplicand = WIDTH'($urandom);
        multiplier   = WIDTH'($urandom);
      end
      if (ready || !busy) rdy_err = 1'b1;
      if (mult_DONE) begin
        got  = 1'b1;
        lat  = i;
        prod = product;
      end
    end
    @(negedge clk);
    after_done  = mult_DONE;
    after_ready = ready;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    valid = 1'b1;
    multiplicand = 8'd3;
    multiplier   = 8'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++;
    if (mult_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", mult_DONE); end
    n_checks++;
    if (product !== '0) begin n_fail++; $display("FAIL reset_product got %h exp 0", product); end
    valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic check_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input bit sgn, input int exp_lat);
    logic [2*WIDTH-1:0] prod, exp_p;
    int lat;
    bit got, rdy_err;
    logic ad, ar;
    exp_p = model(a, b, sgn);
    do_op(a, b, sgn, prod, lat, got, rdy_err, ad, ar);
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_timeout no mult_DONE within 40 cycles", name);
    end else if (prod !== exp_p || lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s (%h x %h) got product %h lat %0d exp %h lat %0d",
               name, a, b, prod, lat, exp_p, exp_lat);
    end
    n_checks++;
    if (rdy_err || ad !== 1'b0 || ar !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_handshake got rdy_err %b done_after %b ready_after %b exp 0 0 1",
               name, rdy_err, ad, ar);
    end
  endtask

  task automatic test_signed();
    check_op("signed_3x-5", 8'd3, 8'hFB, 1'b1, WIDTH + 1);
    n_checks++;
    if (product !== 16'hFFF1) begin
      n_fail++;
      $display("FAIL signed_3x-5_const got %h exp fff1", product);
    end
    for (int k = 0; k < 24; k++) begin
      check_op("signed_rand", WIDTH'($urandom), WIDTH'($urandom), 1'b1, WIDTH + 1);
    end
  endtask

  task automatic test_corners();
    check_op("neg128x-128", 8'h80, 8'h80, 1'b1, WIDTH + 1);
    n_checks++;
    if (product !== 16'h4000) begin
      n_fail++;
      $display("FAIL neg128sq_const got %h exp 4000", product);
    end
    check_op("127x-128", 8'h7F, 8'h80, 1'b1, WIDTH + 1);
    n_checks++;
    if (product !== 16'hC080) begin
      n_fail++;
      $display("FAIL 127x-128_const got %h exp c080", product);
    end
    check_op("-128x127", 8'h80, 8'h7F, 1'b1, WIDTH + 1);
    check_op("-128x1", 8'h80, 8'h01, 1'b1, WIDTH + 1);
    check_op("-1x-128", 8'hFF, 8'h80, 1'b1, WIDTH + 1);
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    logic [2*WIDTH-1:0] prods[$];
    int ready_cnt;
    ready_cnt = 0;
    @(negedge clk);
`ifdef MULT_UNSIGNED_MODE_EN
    mode_signed = 1'b1;
`endif
    multiplicand = 8'd0;
    multiplier   = 8'd7;
    valid        = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i <= 19 && ready) ready_cnt++;
      if (mult_DONE) begin
        done_cyc.push_back(i);
        prods.push_back(product);
        if (done_cyc.size() >= 2) valid = 1'b0;
      end
      if (i == 1) begin
        multiplicand = 8'hFF;
        multiplier   = 8'hFF;
      end
    end
    valid = 1'b0;
    n_checks++;
    if (done_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_pulses got %0d exp 2", done_cyc.size());
    end
    n_checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != 9 || done_cyc[1] != 19) begin
      n_fail++;
      $display("FAIL b2b_timing got %p exp 9 19", done_cyc);
    end
    n_checks++;
    if (prods.size() != 2 || prods[0] !== 16'h0000 || prods[1] !== 16'h0001) begin
      n_fail++;
      $display("FAIL b2b_products got %p exp 0000 0001", prods);
    end
    n_checks++;
    if (ready_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_ready_cycles got %0d exp 1", ready_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bit prod_err;
    check_op("pre_reset", 8'd3, 8'hFB, 1'b1, WIDTH + 1);
    @(negedge clk);
    multiplicand = 8'd5;
    multiplier   = 8'd6;
    valid        = 1'b1;
    @(posedge clk);
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      valid = 1'b0;
      if (mult_DONE) pulses++;
    end
    reset = 1'b0;
    valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || product !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_state got ready %b busy %b product %h exp 1 0 0000",
               ready, busy, product);
    end
    prod_err = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (mult_DONE) pulses++;
      if (product !== '0) prod_err = 1'b1;
    end
    n_checks++;
    if (pulses != 0 || prod_err) begin
      n_fail++;
      $display("FAIL mid_reset_abort got pulses %0d prod_err %b exp 0 0", pulses, prod_err);
    end
  endtask

`ifdef MULT_UNSIGNED_MODE_EN
  task automatic test_unsigned();
    check_op("unsigned_255sq", 8'hFF, 8'hFF, 1'b0, WIDTH + 2);
    n_checks++;
    if (product !== 16'hFE01) begin
      n_fail++;
      $display("FAIL unsigned_255sq_const got %h exp fe01", product);
    end
    check_op("signed_255sq", 8'hFF, 8'hFF, 1'b1, WIDTH + 1);
    n_checks++;
    if (product !== 16'h0001) begin
      n_fail++;
      $display("FAIL signed_255sq_const got %h exp 0001", product);
    end
    for (int k = 0; k < 16; k++) begin
      check_op("unsigned_rand", WIDTH'($urandom), WIDTH'($urandom), 1'b0, WIDTH + 2);
    end
  endtask
`endif

  initial begin
    reset        = 1'b0;
    valid        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
`ifdef MULT_UNSIGNED_MODE_EN
    mode_signed  = 1'b1;
`endif
    test_reset();
    test_signed();
    test_corners();
    test_back_to_back();
    test_reset_mid();
`ifdef MULT_UNSIGNED_MODE_EN
    test_unsigned();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
